pattern_gen: RTL and testbench
==============================

PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter NCH, default 4, number of independent blink channels (1..16).
REQ-002 Parameter CW, default 32, width of phase-length inputs and phase counters.
REQ-003 Parameter RW, default 8, width of the repetition count.
REQ-004 hwclk  input  1  single system clock, all state on rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 start  input  NCH  per-channel start strobe, one cycle, latches config into each channel whose bit is set.
REQ-007 abort  input  NCH  per-channel abort strobe, one cycle.
REQ-008 ontime  input  CW  lit-phase length in cycles, shared config bus.
REQ-009 offtime  input  CW  dark-phase length in cycles, shared config bus.
REQ-010 reps  input  RW  number of off/on repetitions, shared config bus.
REQ-011 cont  input  1  continuous mode: reps ignored, run until abort or restart.
REQ-012 invert  input  1  output polarity: 1 means bright is active-low.
REQ-013 bright  output  NCH  registered LED drive per channel.
REQ-014 busy  output  NCH  registered, high while a channel is in OFF or ON.
REQ-015 done  output  NCH  registered, level, high while a channel is in DONE.

Function
REQ-016 Each channel SHALL run its own FSM with states IDLE, OFF, ON and DONE, plus a CW-bit phase counter and an RW-bit rep counter.
REQ-017 On start[i], channel i SHALL latch ontime, offtime, reps, cont and invert, clear both counters, and enter OFF in the next cycle. If offtime==0 it SHALL enter ON instead.
REQ-018 On start[i], the channel SHALL enter DONE in the next cycle if reps==0 with cont==0, or if ontime==0 and offtime==0, regardless of cont.
REQ-019 OFF SHALL last exactly the latched offtime cycles with the raw lamp off, then go to ON. If ontime==0, the rep SHALL complete at the end of OFF.
REQ-020 ON SHALL last exactly the latched ontime cycles with the raw lamp on, then complete the rep.
REQ-021 On rep completion the rep counter SHALL increment, and the channel SHALL then enter:
- DONE if cont==0 and the new count equals reps;
- otherwise OFF (or ON if offtime==0).
REQ-022 In cont mode the rep counter SHALL wrap modulo 2^RW with no effect on behaviour.
REQ-023 Phase counters SHALL compare against latched length minus one. No ontime+offtime sum is formed, so there is no overflow at any CW.
REQ-024 bright[i] SHALL equal the raw lamp XOR the latched invert. In IDLE and DONE the raw lamp is off, so bright[i] equals latched invert.
REQ-025 Latency: with start at edge 0, bright SHALL show the dark level for edges 1..offtime and the lit level for edges offtime+1..offtime+ontime.
REQ-026 Latency: done SHALL rise at edge reps*(offtime+ontime)+1.
REQ-027 done SHALL stay high until the next start or abort on that channel.
REQ-028 start on a busy or done channel SHALL restart it with the new config. No error is flagged.
REQ-029 abort[i] SHALL force IDLE in the next cycle, with busy=0, done=0 and bright at the latched invert level.
REQ-030 Simultaneous start[i] and abort[i]: abort SHALL win.
REQ-031 Config bus changes SHALL NOT affect a running channel; only the value present at start is used.
REQ-032 Channels SHALL be fully independent. Simultaneous starts on several channels SHALL latch the same config bus value into each.

Reset
REQ-033 rstn low SHALL immediately, without waiting for a clock, force every channel to IDLE and clear all counters, latched config, busy, done and bright to 0.
REQ-034 Release of rstn SHALL be synchronised internally. The first start accepted SHALL be at the second rising edge after release.
REQ-035 Reset asserted mid-pattern SHALL abandon the pattern, with no completion pulse and no resumption.

Verification
REQ-036 Basic run: NCH=4, start[0] with ontime=3, offtime=2, reps=2, invert=0. bright[0] pattern from edge 1 SHALL be 0,0,1,1,1,0,0,1,1,1; done[0] SHALL rise at edge 11; busy[0] SHALL fall at edge 11.
REQ-037 Zero cases: reps=0, cont=0 -> done at edge 1, bright never 1. offtime=0, ontime=2, reps=3 -> bright SHALL be high for edges 1..6, then done at edge 7.
REQ-038 Continuous mode: cont=1, ontime=1, offtime=1, RW=8. Run 600 cycles with no done, bright toggling every cycle across the rep-counter wrap. abort at edge 600 -> IDLE at edge 601 with bright=0.
REQ-039 Invert and abort: invert=1, ontime=4, offtime=4, reps=5, start[2]. bright[2] SHALL be high in OFF and low in ON. abort[2] asserted together with start[2] at edge 10 -> IDLE, bright[2]=1.
REQ-040 Independence and restart: start[1] with reps=3, then change the config bus every cycle; channel 1 timing SHALL be unchanged. A restart of channel 1 with reps=1 during ON SHALL begin a fresh OFF the next cycle.
REQ-041 Async reset: drop rstn between clock edges mid-pattern. All outputs SHALL be 0 before the next edge. A start after release SHALL behave as in REQ-036.

Source files
------------

// File: rtl/pattern_gen.sv
// pattern_gen: multi-channel LED blink sequencer with per-channel off/on phase
// timing, repetition count, continuous mode and output polarity.
module pattern_gen #(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter int RW  = 8
) (
    input  logic           hwclk,
    input  logic           rstn,
    input  logic [NCH-1:0] start,
    input  logic [NCH-1:0] abort,
    input  logic [CW-1:0]  ontime,
    input  logic [CW-1:0]  offtime,
    input  logic [RW-1:0]  reps,
    input  logic           cont,
    input  logic           invert,
    output logic [NCH-1:0] bright,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OFF  = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Release of rstn becomes visible one edge later, so starts are honoured from the second edge on.
    logic run_q;
    always_ff @(posedge hwclk or negedge rstn)
        if (!rstn) run_q <= 1'b0;
        else       run_q <= 1'b1;

    genvar g;
    for (g = 0; g < NCH; g++) begin : g_ch
        logic [1:0]    state_q, state_d, rep_st;
        logic [CW-1:0] cnt_q, cnt_d, on_q, on_d, off_q, off_d;
        logic [RW-1:0] rep_q, rep_d, reps_q, reps_d, rep_inc;
        logic          cont_q, cont_d, inv_q, inv_d, last;
        logic          bright_q, busy_q, done_q;

        assign rep_inc = rep_q + RW'(1);
        assign rep_st  = (!cont_q && rep_inc == reps_q) ? S_DONE : (off_q == '0 ? S_ON : S_OFF);
        assign last    = state_q == S_ON ? cnt_q == on_q - CW'(1) : cnt_q == off_q - CW'(1);

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rep_d   = rep_q;
            on_d    = on_q;
            off_d   = off_q;
            reps_d  = reps_q;
            cont_d  = cont_q;
            inv_d   = inv_q;
            if (abort[g]) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                rep_d   = '0;
            end else if (start[g] && run_q) begin
                on_d    = ontime;
                off_d   = offtime;
                reps_d  = reps;
                cont_d  = cont;
                inv_d   = invert;
                cnt_d   = '0;
                rep_d   = '0;
                state_d = ((reps == '0 && !cont) || (ontime == '0 && offtime == '0)) ? S_DONE :
                          (offtime == '0 ? S_ON : S_OFF);
            end else if (state_q == S_OFF || state_q == S_ON) begin
                if (!last) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (state_q == S_OFF && on_q != '0) begin
                        state_d = S_ON;
                    end else begin
                        rep_d   = rep_inc;
                        state_d = rep_st;
                    end
                end
            end
        end

        always_ff @(posedge hwclk or negedge rstn) begin
            if (!rstn) begin
                state_q  <= S_IDLE;
                cnt_q    <= '0;
                rep_q    <= '0;
                on_q     <= '0;
                off_q    <= '0;
                reps_q   <= '0;
                cont_q   <= 1'b0;
                inv_q    <= 1'b0;
                bright_q <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                rep_q    <= rep_d;
                on_q     <= on_d;
                off_q    <= off_d;
                reps_q   <= reps_d;
                cont_q   <= cont_d;
                inv_q    <= inv_d;
                bright_q <= (state_d == S_ON) ^ inv_d;
                busy_q   <= state_d == S_OFF || state_d == S_ON;
                done_q   <= state_d == S_DONE;
            end
        end

        assign bright[g] = bright_q;
        assign busy[g]   = busy_q;
        assign done[g]   = done_q;
    end
endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed vector bench for pattern_gen (NCH=4, CW=32, RW=8).
module tb_pattern_gen;
    logic        hwclk = 1'b0;
    logic        rstn;
    logic [3:0]  start, abort, bright, busy, done;
    logic [31:0] ontime, offtime;
    logic [7:0]  reps;
    logic        cont, invert;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [3:0]  st, ab;
        logic [31:0] on, off;
        logic [7:0]  rp;
        logic        ct, iv;
        logic [3:0]  eb, ebu, ed;
    } vec_t;
    vec_t tbl[13];

    pattern_gen #(.NCH(4), .CW(32), .RW(8)) dut (
        .hwclk(hwclk), .rstn(rstn), .start(start), .abort(abort),
        .ontime(ontime), .offtime(offtime), .reps(reps), .cont(cont), .invert(invert),
        .bright(bright), .busy(busy), .done(done)
    );

    always #5 hwclk = ~hwclk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge hwclk);
        #1;
    endtask

    task automatic cfg(input logic [31:0] on, input logic [31:0] off, input logic [7:0] rp,
                       input logic ct, input logic iv);
        ontime = on; offtime = off; reps = rp; cont = ct; invert = iv;
    endtask

    function automatic vec_t mk(input logic [3:0] st, input logic [3:0] ab, input logic [3:0] eb,
                                input logic [3:0] ebu, input logic [3:0] ed);
        vec_t v;
        v.st = st; v.ab = ab; v.on = 3; v.off = 2; v.rp = 2; v.ct = 0; v.iv = 0;
        v.eb = eb; v.ebu = ebu; v.ed = ed;
        return v;
    endfunction

    // Reference timeline: t=1 is the edge that captures start.
    function automatic logic m_fin(input int t, input int on, input int off, input int rp);
        return t > rp * (on + off);
    endfunction

    function automatic logic m_lit(input int t, input int on, input int off, input int rp);
        if (m_fin(t, on, off, rp)) return 1'b0;
        return ((t - 1) % (on + off)) >= off;
    endfunction

    initial begin
        rstn = 1'b0; start = '0; abort = '0;
        cfg(0, 0, 0, 0, 0);
        #2;
        chk("reset_bright", bright, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(posedge hwclk); #3 rstn = 1'b1;
        step(); step();

        tbl[0]  = mk(4'b0001, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 1, 0);
        tbl[2]  = mk(0, 0, 1, 1, 0);
        tbl[3]  = mk(0, 0, 1, 1, 0);
        tbl[4]  = mk(0, 0, 1, 1, 0);
        tbl[5]  = mk(0, 0, 0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 1, 0);
        tbl[7]  = mk(0, 0, 1, 1, 0);
        tbl[8]  = mk(0, 0, 1, 1, 0);
        tbl[9]  = mk(0, 0, 1, 1, 0);
        tbl[10] = mk(0, 0, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 1);
        tbl[12] = mk(0, 4'b0001, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            start = tbl[i].st; abort = tbl[i].ab;
            cfg(tbl[i].on, tbl[i].off, tbl[i].rp, tbl[i].ct, tbl[i].iv);
            step();
            chk($sformatf("basic_bright_e%0d", i + 1), bright, tbl[i].eb);
            chk($sformatf("basic_busy_e%0d", i + 1), busy, tbl[i].ebu);
            chk($sformatf("basic_done_e%0d", i + 1), done, tbl[i].ed);
        end
        start = '0; abort = '0;

        cfg(3, 2, 0, 0, 0); start = 4'b0001; step(); start = '0;
        for (int k = 1; k <= 3; k++) begin
            chk("reps0_done", done[0], 1);
            chk("reps0_bright", bright[0], 0);
            chk("reps0_busy", busy[0], 0);
            step();
        end
        abort = 4'b0001; step(); abort = '0;
        chk("reps0_abort_done", done[0], 0);

        cfg(2, 0, 3, 0, 0); start = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            step(); start = '0;
            chk($sformatf("off0_bright_e%0d", k), bright[0], k <= 6);
            chk($sformatf("off0_done_e%0d", k), done[0], k == 7);
        end
        abort = 4'b0001; step(); abort = '0;

        cfg(0, 0, 5, 1, 0); start = 4'b0001; step(); start = '0;
        chk("both0_cont_done", done[0], 1);
        chk("both0_cont_busy", busy[0], 0);
        abort = 4'b0001; step(); abort = '0;

        cfg(0, 2, 2, 0, 0); start = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            step(); start = '0;
            chk($sformatf("on0_bright_e%0d", k), bright[0], 0);
            chk($sformatf("on0_busy_e%0d", k), busy[0], k <= 4);
            chk($sformatf("on0_done_e%0d", k), done[0], k == 5);
        end
        abort = 4'b0001; step(); abort = '0;

        cfg(1, 1, 0, 1, 0); start = 4'b1000;
        for (int k = 1; k <= 600; k++) begin
            step(); start = '0;
            chk($sformatf("cont_bright_e%0d", k), bright[3], (k % 2) == 0);
            chk($sformatf("cont_done_e%0d", k), done[3], 0);
        end
        abort = 4'b1000; step(); abort = '0;
        chk("cont_abort_bright", bright[3], 0);
        chk("cont_abort_busy", busy[3], 0);
        chk("cont_abort_done", done[3], 0);

        cfg(4, 4, 5, 0, 1); start = 4'b0100;
        for (int k = 1; k <= 9; k++) begin
            step(); start = '0;
            chk($sformatf("inv_bright_e%0d", k), bright[2], !(k >= 5 && k <= 8));
            chk($sformatf("inv_busy_e%0d", k), busy[2], 1);
        end
        cfg(7, 1, 1, 0, 0); start = 4'b0100; abort = 4'b0100;
        step(); start = '0; abort = '0;
        chk("inv_abort_bright", bright[2], 1);
        chk("inv_abort_busy", busy[2], 0);
        chk("inv_abort_done", done[2], 0);
        step();
        chk("inv_abort_hold_busy", busy[2], 0);

        cfg(3, 2, 3, 0, 0); start = 4'b0011;
        for (int k = 1; k <= 16; k++) begin
            step(); start = '0;
            chk($sformatf("ind_ch0_bright_e%0d", k), bright[0], m_lit(k, 3, 2, 3));
            chk($sformatf("ind_ch0_done_e%0d", k), done[0], m_fin(k, 3, 2, 3));
            if (k <= 8) begin
                chk($sformatf("ind_ch1_bright_e%0d", k), bright[1], m_lit(k, 3, 2, 3));
                chk($sformatf("ind_ch1_busy_e%0d", k), busy[1], 1);
            end else begin
                chk($sformatf("rst1_ch1_bright_e%0d", k), bright[1], m_lit(k - 8, 2, 1, 1));
                chk($sformatf("rst1_ch1_done_e%0d", k), done[1], m_fin(k - 8, 2, 1, 1));
            end
            if (k == 8) begin
                cfg(2, 1, 1, 0, 0); start = 4'b0010;
            end else begin
                cfg($urandom, $urandom, 8'($urandom), 1'($urandom), 1'($urandom));
            end
        end
        abort = 4'b0011; step(); abort = '0;

        cfg(3, 2, 2, 0, 0); start = 4'b0001; step(); start = '0;
        step(); step();
        #2 rstn = 1'b0;
        #1;
        chk("async_bright", bright, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        @(posedge hwclk); #4 rstn = 1'b1; start = 4'b0001;
        step();
        chk("sync_first_edge_busy", busy[0], 0);
        for (int k = 2; k <= 12; k++) begin
            step(); start = '0;
            chk($sformatf("post_rst_bright_e%0d", k), bright[0], m_lit(k - 1, 3, 2, 2));
            chk($sformatf("post_rst_done_e%0d", k), done[0], m_fin(k - 1, 3, 2, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
